// File: rtl/one_hot_enc_pipe.sv
// Registered binary-to-one-hot/one-cold/thermometer encoder on a valid/ready stream.
// An output register plus one skid entry keep ready_o a flop with no path from ready_i.
module one_hot_enc_pipe #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [BIN_W-1:0]     bin_i,
  input  logic [1:0]           mode_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ONE_HOT_W-1:0] one_hot_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  // state    | meaning
  // ST_EMPTY | output register empty, skid empty
  // ST_HALF  | output register holds a beat, skid empty
  // ST_FULL  | output register and skid both hold a beat
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_HOT   = 2'b00,
    MODE_COLD  = 2'b01,
    MODE_THERM = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  localparam logic [BIN_W:0] MAX_IDX = (BIN_W+1)'(ONE_HOT_W - 1);

  state_e                 state, state_next;
  logic                   ready_q;
  logic [ONE_HOT_W-1:0]   out_data, skid_data;
  logic                   out_err, skid_err;
  logic [ERR_CNT_W-1:0]   err_cnt;

  logic                   accept;
  logic                   load_out_new, load_out_skid, load_skid;
  logic [ONE_HOT_W-1:0]   hot_vec, therm_vec, enc_data;
  logic                   enc_err;

  assign accept = valid_i & ready_q;

  always_comb begin
    hot_vec   = '0;
    therm_vec = '0;
    for (int i = 0; i < ONE_HOT_W; i++) begin
      hot_vec[i]   = (bin_i == BIN_W'(i));
      therm_vec[i] = (BIN_W'(i) <= bin_i);
    end
  end

  always_comb begin
    enc_data = '0;
    enc_err  = ({1'b0, bin_i} > MAX_IDX);
    case (mode_e'(mode_i))
      MODE_HOT:   enc_data = hot_vec;
      MODE_COLD:  enc_data = ~hot_vec;
      MODE_THERM: enc_data = therm_vec;
      default:    enc_err  = 1'b1;
    endcase
    // Any error forces an all-zero vector, whatever the mode.
    if (enc_err) enc_data = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_out_new = 1'b1;
          state_next   = ST_HALF;
        end
      end
      ST_HALF: begin
        if (accept && !ready_i) begin
          load_skid  = 1'b1;
          state_next = ST_FULL;
        end else if (accept) begin
          load_out_new = 1'b1;
        end else if (ready_i) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // ready_q is low here, so no new beat can arrive alongside the drain.
        if (ready_i) begin
          load_out_skid = 1'b1;
          state_next    = ST_HALF;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b1;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      ready_q <= (state_next != ST_FULL);
      if (load_out_new) begin
        out_data <= enc_data;
        out_err  <= enc_err;
      end else if (load_out_skid) begin
        out_data <= skid_data;
        out_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= enc_data;
        skid_err  <= enc_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         err_cnt <= '0;
    else if (accept && enc_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
  end

  assign ready_o   = ready_q;
  assign valid_o   = (state != ST_EMPTY);
  assign one_hot_o = out_data;
  assign err_o     = out_err;
  assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_one_hot_enc_pipe.sv
// Directed bench for one_hot_enc_pipe: a default instance and a narrow one
// (ONE_HOT_W=10, ERR_CNT_W=2) share clock, reset and stimulus.
module tb_one_hot_enc_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_i;
  logic [3:0]  bin_i;
  logic [1:0]  mode_i;

  logic        ready_o, valid_o, err_o;
  logic [15:0] one_hot_o;
  logic [7:0]  err_cnt_o;

  logic        n_ready_o, n_valid_o, n_err_o;
  logic [9:0]  n_one_hot_o;
  logic [1:0]  n_err_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  one_hot_enc_pipe #(.BIN_W(4), .ONE_HOT_W(16), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .bin_i(bin_i), .mode_i(mode_i), .valid_o(valid_o), .ready_i(ready_i),
    .one_hot_o(one_hot_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  one_hot_enc_pipe #(.BIN_W(4), .ONE_HOT_W(10), .ERR_CNT_W(2)) dut_n (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(n_ready_o),
    .bin_i(bin_i), .mode_i(mode_i), .valid_o(n_valid_o), .ready_i(ready_i),
    .one_hot_o(n_one_hot_o), .err_o(n_err_o), .err_cnt_o(n_err_cnt_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_i = 1'b0; ready_i = 1'b0; bin_i = '0; mode_i = 2'b00;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid_o !== 1'b0 || one_hot_o !== 16'h0 || err_o !== 1'b0 || err_cnt_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h err=%b cnt=%0d, exp 0/0000/0/0",
               valid_o, one_hot_o, err_o, err_cnt_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b exp 1", ready_o);
    end
  endtask

  task automatic test_sweep();
    ready_i = 1'b1; valid_i = 1'b1; mode_i = 2'b00;
    for (int v = 0; v < 16; v++) begin
      logic [15:0] exp;
      exp = 16'h1 << v;
      bin_i = 4'(v);
      step();
      checks++;
      if (valid_o !== 1'b1 || one_hot_o !== exp || err_o !== 1'b0 || ready_o !== 1'b1) begin
        errors++;
        $display("FAIL sweep_%0d: got valid=%b data=%h err=%b ready=%b, exp 1/%h/0/1",
                 v, valid_o, one_hot_o, err_o, ready_o, exp);
      end
    end
    valid_i = 1'b0;
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sweep_drain: got valid=%b exp 0", valid_o);
    end
  endtask

  task automatic test_modes();
    logic [1:0]  m_tab [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    logic [3:0]  b_tab [4] = '{4'd3, 4'd3, 4'd15, 4'd0};
    logic [15:0] e_tab [4] = '{16'hFFF7, 16'h000F, 16'hFFFF, 16'h0001};
    ready_i = 1'b1; valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mode_i = m_tab[k]; bin_i = b_tab[k];
      step();
      checks++;
      if (valid_o !== 1'b1 || one_hot_o !== e_tab[k] || err_o !== 1'b0) begin
        errors++;
        $display("FAIL mode_%0d: got valid=%b data=%h err=%b, exp 1/%h/0",
                 k, valid_o, one_hot_o, err_o, e_tab[k]);
      end
    end
    valid_i = 1'b0;
    step();
  endtask

  task automatic test_range_errors();
    logic [1:0] m_tab [3] = '{2'b00, 2'b10, 2'b11};
    logic [3:0] b_tab [3] = '{4'd12, 4'd9, 4'd2};
    logic [9:0] e_tab [3] = '{10'h000, 10'h3FF, 10'h000};
    logic       r_tab [3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0] c_tab [3] = '{2'd1, 2'd1, 2'd2};
    do_reset();
    ready_i = 1'b1; valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mode_i = m_tab[k]; bin_i = b_tab[k];
      step();
      checks++;
      if (n_valid_o !== 1'b1 || n_one_hot_o !== e_tab[k] || n_err_o !== r_tab[k] ||
          n_err_cnt_o !== c_tab[k]) begin
        errors++;
        $display("FAIL range_%0d: got valid=%b data=%h err=%b cnt=%0d, exp 1/%h/%b/%0d",
                 k, n_valid_o, n_one_hot_o, n_err_o, n_err_cnt_o, e_tab[k], r_tab[k], c_tab[k]);
      end
    end
    // bin 12 is in range for the 16-wide instance; only mode 11 counted there
    checks++;
    if (err_cnt_o !== 8'd1 || err_o !== 1'b1 || one_hot_o !== 16'h0) begin
      errors++;
      $display("FAIL range_wide: got cnt=%0d err=%b data=%h, exp 1/1/0000",
               err_cnt_o, err_o, one_hot_o);
    end
    valid_i = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_i = 1'b0; valid_i = 1'b1; mode_i = 2'b00;
    bin_i = 4'd1; step();
    bin_i = 4'd2; step();
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low: got %b exp 0", ready_o);
    end
    bin_i = 4'd3; step();
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1 || one_hot_o !== 16'h0002) begin
      errors++;
      $display("FAIL bp_hold: got ready=%b valid=%b data=%h, exp 0/1/0002",
               ready_o, valid_o, one_hot_o);
    end
    ready_i = 1'b1;
    step();
    checks++;
    if (valid_o !== 1'b1 || one_hot_o !== 16'h0004 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got valid=%b data=%h ready=%b, exp 1/0004/1",
               valid_o, one_hot_o, ready_o);
    end
    step();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || one_hot_o !== 16'h0008) begin
      errors++;
      $display("FAIL bp_third: got valid=%b data=%h, exp 1/0008", valid_o, one_hot_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got valid=%b exp 0", valid_o);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] c_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    ready_i = 1'b1; valid_i = 1'b1; mode_i = 2'b11; bin_i = 4'd4;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (n_err_cnt_o !== c_tab[k] || n_err_o !== 1'b1) begin
        errors++;
        $display("FAIL sat_%0d: got cnt=%0d err=%b, exp %0d/1", k, n_err_cnt_o, n_err_o, c_tab[k]);
      end
    end
    checks++;
    if (err_cnt_o !== 8'd5) begin
      errors++;
      $display("FAIL sat_wide: got cnt=%0d exp 5", err_cnt_o);
    end
    valid_i = 1'b0;
    step();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    ready_i = 1'b0; valid_i = 1'b1;
    mode_i = 2'b11; bin_i = 4'd4; step();
    mode_i = 2'b00; bin_i = 4'd5; step();
    valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1 || err_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL mid_prefill: got ready=%b valid=%b cnt=%0d, exp 0/1/1",
               ready_o, valid_o, err_cnt_o);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || err_cnt_o !== 8'd0 || one_hot_o !== 16'h0) begin
      errors++;
      $display("FAIL mid_async: got valid=%b cnt=%0d data=%h, exp 0/0/0000",
               valid_o, err_cnt_o, one_hot_o);
    end
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: got ready=%b valid=%b, exp 1/0", ready_o, valid_o);
    end
    ready_i = 1'b1; valid_i = 1'b1; mode_i = 2'b00; bin_i = 4'd7;
    step();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || one_hot_o !== 16'h0080 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_next: got valid=%b data=%h err=%b, exp 1/0080/0",
               valid_o, one_hot_o, err_o);
    end
    step();
  endtask

  initial begin
    reset = 1'b1;
    valid_i = 1'b0; ready_i = 1'b0; bin_i = '0; mode_i = 2'b00;
    test_reset();
    test_sweep();
    test_modes();
    test_range_errors();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/one_hot_enc_pipe.md
Name: one_hot_enc_pipe

Overview:
- Parametrised, registered binary-to-one-hot encoder with three output codes: one-hot, one-cold and thermometer.
- Sits on a valid/ready stream: binary index in, encoded vector out, with a 2-entry skid buffer so ready_o is registered.
- Flags out-of-range indices and illegal modes, and keeps a saturating error counter for debug.
- Successor to the combinational one_hot encoder, for use in pipelined select/mask paths.

Parameters:
- BIN_W, 4, width of the binary index input.
- ONE_HOT_W, 16, width of the encoded output. Legal range 2 to 2**BIN_W.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  input beat valid.
- ready_o  output  1  block can accept a beat. Registered.
- bin_i  input  BIN_W  binary index.
- mode_i  input  2  code select, sampled with bin_i: 00 one-hot, 01 one-cold, 10 thermometer, 11 reserved.
- valid_o  output  1  output beat valid.
- ready_i  input  1  downstream accepts the beat.
- one_hot_o  output  ONE_HOT_W  encoded vector.
- err_o  output  1  sideband flag travelling with the beat: index out of range or reserved mode.
- err_cnt_o  output  ERR_CNT_W  count of errored beats accepted, saturating.

Behaviour:
- Reset (async assert, sync release):
  - valid_o=0, one_hot_o=0, err_o=0, err_cnt_o=0.
  - Skid register empty, so ready_o=1 once reset deasserts.
  - No beat is accepted while reset is high.
  - Asserting reset mid-transfer discards all held beats immediately. valid_o drops in the same instant.
- Handshakes:
  - Input accept = valid_i & ready_o.
  - Output transfer = valid_o & ready_i.
  - valid_o, once high, holds one_hot_o and err_o stable until a transfer occurs.
- Encoding for index v=bin_i:
  - one-hot: bit v = 1, all others 0.
  - one-cold: bitwise inverse of the one-hot vector.
  - thermometer: bits [v:0] = 1, bits above v = 0. v=0 gives 1; v=ONE_HOT_W-1 gives all ones.
- Errors:
  - If v > ONE_HOT_W-1, or mode_i = 11, then one_hot_o = all zeros in every mode and err_o = 1.
  - err_cnt_o increments by 1 on each accepted errored beat. It holds at 2**ERR_CNT_W-1 and does not wrap.
  - The count updates on the accept edge, not on the output transfer.
- Latency: 1 cycle. A beat accepted at edge N appears on the outputs after edge N when the output register is free.
- Output register plus skid register:
  - Accept with output register empty, or with a transfer in the same cycle: the beat loads the output register.
  - Accept with the output register full and ready_i=0: the beat loads the skid register, and ready_o goes 0 next cycle.
  - Transfer with the skid register full: skid moves to the output register, the skid empties, and ready_o goes 1 next cycle.
  - ready_o = ~skid_full, registered. No combinational path exists from ready_i to ready_o.
- Full throughput: with ready_i held at 1, one beat per cycle, no bubbles.
- Ordering is strictly preserved. No beat is dropped or duplicated.

Test Plan:
- Sweep, BIN_W=4, ONE_HOT_W=16, ready_i=1, mode 00, bin_i 0..15 back-to-back -> one cycle later one_hot_o = 1<<bin_i (bin_i=5 gives 0x0020), one beat per cycle, err_o=0.
- Mode coverage, same config -> mode 01 with bin_i=3 gives 0xFFF7; mode 10 with bin_i=3 gives 0x000F; mode 10 with bin_i=15 gives 0xFFFF; mode 10 with bin_i=0 gives 0x0001.
- Range and mode errors:
  - ONE_HOT_W=10, bin_i=12 in mode 00 -> one_hot_o=0, err_o=1, err_cnt_o 0->1.
  - bin_i=9 in mode 10 -> 0x3FF, err_o=0.
  - mode 11 with bin_i=2 -> 0, err_o=1, err_cnt_o=2.
- Backpressure, ready_i=0 while 3 beats (bin_i=1,2,3) are offered -> first two accepted, ready_o=0 on the third.
  - On raising ready_i, outputs are 0x0002, 0x0004, 0x0008 in order, with none lost.
- Saturation, ERR_CNT_W=2, 5 errored beats -> err_cnt_o reads 1,2,3,3,3.
- Reset mid-stream with the skid register full -> valid_o=0 and err_cnt_o=0 asynchronously; ready_o=1 after release; the next beat bin_i=7 gives 0x0080.
